// File: rtl/decode_pkg.sv
// Opcode map and write-class helper shared by the decode-stage transmitter.
package decode_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_NOP     = 5'b00000;
  localparam logic [OP_W-1:0] OP_ALU_LO  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ALU_HI  = 5'b00110;
  localparam logic [OP_W-1:0] OP_STORE   = 5'b00111;
  localparam logic [OP_W-1:0] OP_MEM_LO  = 5'b01000;
  localparam logic [OP_W-1:0] OP_MEM_HI  = 5'b01011;
  localparam logic [OP_W-1:0] OP_CTL_LO  = 5'b11000;
  localparam logic [OP_W-1:0] OP_LDI     = 5'b11001;
  localparam logic [OP_W-1:0] OP_CTL_HI  = 5'b11100;
  localparam logic [OP_W-1:0] OP_LINK    = 5'b11110;

  localparam logic [OP_W-1:0] IMM_OP_DEFAULT = OP_LDI;

  // 1 when the opcode writes its destination register
  function automatic logic is_dest_write(input logic [OP_W-1:0] op);
    return ((op >= OP_ALU_LO) && (op <= OP_ALU_HI)) ||
           ((op >= OP_MEM_LO) && (op <= OP_MEM_HI)) ||
           ((op >= OP_CTL_LO) && (op <= OP_CTL_HI)) ||
           (op == OP_LINK);
  endfunction

endpackage

// File: rtl/decode_transmitter_pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: an output register plus one skid entry.
module dtp_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         out_free;

  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // in_ready mirrors the next skid state so it is a pure register output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b1;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
      in_ready <= 1'b1;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      in_ready   <= 1'b0;
    end
  end

endmodule

// File: rtl/decode_transmitter_pipe.sv
// Decode-stage transmitter: masks dest/immediate by opcode class, buffers toward execute.
module decode_transmitter_pipe
  import decode_pkg::*;
#(
  parameter int unsigned     OPW    = 5,
  parameter int unsigned     REGW   = 4,
  parameter int unsigned     DATAW  = 32,
  parameter logic [OPW-1:0]  IMM_OP = OPW'(IMM_OP_DEFAULT),
  parameter int unsigned     CNTW   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   opcode_in,
  input  logic [REGW-1:0]  dest_in,
  input  logic [REGW-1:0]  s1_in,
  input  logic [REGW-1:0]  s2_in,
  input  logic [DATAW-1:0] imm_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPW-1:0]   opcode_out,
  output logic [REGW-1:0]  dest_out,
  output logic             dest_we,
  output logic [REGW-1:0]  s1_out,
  output logic [REGW-1:0]  s2_out,
  output logic [DATAW-1:0] imm_out,
  output logic [CNTW-1:0]  stall_cnt
);

  localparam int unsigned PW = OPW + 3 * REGW + 1 + DATAW;

  logic             we_c;
  logic [REGW-1:0]  dest_m_c;
  logic [DATAW-1:0] imm_m_c;
  logic [PW-1:0]    in_payload;
  logic [PW-1:0]    out_payload;

  // Masking happens before the buffer so stored entries are already final
  always_comb begin
    we_c     = is_dest_write(OP_W'(opcode_in));
    dest_m_c = we_c ? dest_in : '0;
    imm_m_c  = (opcode_in == IMM_OP) ? imm_in : '0;
  end

  assign in_payload = {opcode_in, dest_m_c, we_c, s1_in, s2_in, imm_m_c};

  dtp_skid_buf #(.W(PW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {opcode_out, dest_out, dest_we, s1_out, s2_out, imm_out} = out_payload;

  // Saturating count of stalled output cycles; survives flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule
